// File: rtl/md_pkg.sv
// Shared definitions for the HILO issue controller.
//   - HILO opcode encodings seen on the E-stage and driven to the unit
//   - FSM state encoding for the latency shadow
//   - opcode classification helpers
package md_pkg;

  localparam int unsigned OP_W   = 4;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 32;

  localparam logic [OP_W-1:0] MD_MFHI  = 4'b0000;
  localparam logic [OP_W-1:0] MD_MFLO  = 4'b0001;
  localparam logic [OP_W-1:0] MD_MTHI  = 4'b0010;
  localparam logic [OP_W-1:0] MD_MTLO  = 4'b0011;
  localparam logic [OP_W-1:0] MD_MULTU = 4'b0100;
  localparam logic [OP_W-1:0] MD_DIVU  = 4'b0101;
  localparam logic [OP_W-1:0] MD_MULT  = 4'b0110;
  localparam logic [OP_W-1:0] MD_DIV   = 4'b0111;
  localparam logic [OP_W-1:0] MD_NOP   = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2
  } md_state_e;

  // Ops that start a multi-cycle unit operation: 0100..0111.
  function automatic logic is_start_op(input logic [OP_W-1:0] op);
    return (op[3:2] == 2'b01);
  endfunction

  // Divide flavours (divu/div) have bit 0 set within the start-op range.
  function automatic logic is_div_op(input logic [OP_W-1:0] op);
    return is_start_op(op) && op[0];
  endfunction

endpackage

// File: rtl/md_lat_shadow.sv
// Local latency shadow of the HILO unit.
// Tracks how long the unit should stay busy after each accepted start and
// flags (sticky) any cycle where that prediction disagrees with the unit.
// Ports:
//   clk, reset  : clock, async active-high reset
//   issue       : a start op is being sent to the unit this cycle
//   issue_div   : the op being issued is a divide (else a multiply)
//   md_busy     : busy reported by the HILO unit
//   sync_err    : sticky shadow/unit disagreement flag (registered)
module md_lat_shadow
  import md_pkg::*;
#(
  parameter int unsigned MUL_LAT = 5,
  parameter int unsigned DIV_LAT = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic issue,
  input  logic issue_div,
  input  logic md_busy,
  output logic sync_err
);

  localparam int unsigned MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int unsigned LAT_BITS = $clog2(MAX_LAT + 1);
  localparam int unsigned SH_W = (LAT_BITS > 4) ? LAT_BITS : 4;

  md_state_e       state;
  md_state_e       state_nxt;
  logic            accept;
  logic [SH_W-1:0] cnt;
  logic            pred_busy;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state: leave IDLE on issue, return on the last busy cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (issue) begin
          state_nxt = issue_div ? ST_DIV : ST_MUL;
        end
      end
      ST_MUL, ST_DIV: begin
        if (cnt == SH_W'(1)) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // FSM output: a new start is only tracked from IDLE.
  always_comb begin
    accept = 1'b0;
    if (state == ST_IDLE) begin
      accept = 1'b1;
    end
  end

  // Latency counter: load on accepted issue, otherwise drain to zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (issue && accept) begin
      cnt <= issue_div ? SH_W'(DIV_LAT) : SH_W'(MUL_LAT);
    end else if (cnt != '0) begin
      cnt <= cnt - SH_W'(1);
    end
  end

  assign pred_busy = (cnt != '0);

  // Sticky mismatch flag; only reset clears it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_err <= 1'b0;
    end else if (pred_busy != md_busy) begin
      sync_err <= 1'b1;
    end
  end

endmodule

// File: rtl/md_issue_ctrl.sv
// Issue and hazard controller in front of the HILO multiply/divide unit.
// Gates E-stage HILO ops into the unit, cancels them on req, produces the
// D-stage HILO hazard stall and counts stalled cycles.
// Ports:
//   clk, reset        : clock, async active-high reset
//   e_valid           : E-stage holds a real instruction
//   e_md_op           : E-stage HILO opcode
//   e_rs, e_rt        : E-stage forwarded operands
//   d_md_use          : D-stage instruction is a HILO op
//   req               : interrupt/exception request, kills E this cycle
//   md_busy           : busy from the HILO unit
//   md_op             : HILO_op to the unit (combinational)
//   md_a1, md_a2      : A1/A2 to the unit (combinational passthrough)
//   md_start          : start to the unit (combinational)
//   stall             : pipeline freeze for HILO hazards (combinational)
//   sync_err          : sticky shadow/unit disagreement flag
//   stall_cnt         : saturating count of stalled cycles
module md_issue_ctrl
  import md_pkg::*;
#(
  parameter int unsigned MUL_LAT = 5,
  parameter int unsigned DIV_LAT = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              e_valid,
  input  logic [OP_W-1:0]   e_md_op,
  input  logic [DATA_W-1:0] e_rs,
  input  logic [DATA_W-1:0] e_rt,
  input  logic              d_md_use,
  input  logic              req,
  input  logic              md_busy,
  output logic [OP_W-1:0]   md_op,
  output logic [DATA_W-1:0] md_a1,
  output logic [DATA_W-1:0] md_a2,
  output logic              md_start,
  output logic              stall,
  output logic              sync_err,
  output logic [CNT_W-1:0]  stall_cnt
);

  logic kill;
  logic start_op;
  logic issue;

  assign kill     = !e_valid || req;
  assign start_op = is_start_op(e_md_op);

  assign md_a1 = e_rs;
  assign md_a2 = e_rt;

  // Dead instructions and starts the unit cannot take become NOP, so
  // mthi/mtlo never commit under req and mfhi/mflo of a dead op read 0.
  always_comb begin
    md_op = e_md_op;
    if (kill || (start_op && md_busy)) begin
      md_op = MD_NOP;
    end
  end

  assign issue    = e_valid && !req && !md_busy && start_op;
  assign md_start = issue;
  assign stall    = d_md_use && (issue || md_busy);

  md_lat_shadow #(
    .MUL_LAT (MUL_LAT),
    .DIV_LAT (DIV_LAT)
  ) u_shadow (
    .clk       (clk),
    .reset     (reset),
    .issue     (issue),
    .issue_div (is_div_op(e_md_op)),
    .md_busy   (md_busy),
    .sync_err  (sync_err)
  );

  // Saturating stall-cycle counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (stall && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule
